// File: rtl/multi_clk_div_pkg.sv
// Shared defaults and helpers for the multi-channel clock-enable generator.
package multi_clk_div_pkg;

  // 1 Hz square wave from a 1 MHz clock
  localparam int unsigned DEFAULT_HALF_DEF = 500000;

  // Width of a channel index, never less than one bit
  function automatic int unsigned sel_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/div_channel.sv
// One divider channel: programmable half-period, tick strobe and square wave.
module div_channel
  import multi_clk_div_pkg::*;
#(
  parameter int unsigned CNT_W        = 20,
  parameter int unsigned DEFAULT_HALF = DEFAULT_HALF_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic             wr,
  input  logic [CNT_W-1:0] wr_val,
  output logic             tick,
  output logic             sq
);

  localparam logic [CNT_W-1:0] RST_HALF = CNT_W'(DEFAULT_HALF);
  localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

  logic [CNT_W-1:0] half_q, half_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sq_q, sq_d;
  logic             tick_q, tick_d;

  // Next-state: a write updates half even when the channel is also being cleared
  always_comb begin
    half_d = half_q;
    cnt_d  = cnt_q;
    sq_d   = sq_q;
    tick_d = 1'b0;
    if (wr) begin
      half_d = wr_val;
    end
    if (clr || wr || (half_q == '0)) begin
      cnt_d = '0;
      sq_d  = 1'b0;
    end else if (en) begin
      if (cnt_q == half_q - ONE) begin
        cnt_d  = '0;
        tick_d = 1'b1;
        sq_d   = ~sq_q;
      end else begin
        cnt_d = cnt_q + ONE;
      end
    end
  end

  // State registers with synchronous reset to the default rate
  always_ff @(posedge clk) begin
    if (rst) begin
      half_q <= RST_HALF;
      cnt_q  <= '0;
      sq_q   <= 1'b0;
      tick_q <= 1'b0;
    end else begin
      half_q <= half_d;
      cnt_q  <= cnt_d;
      sq_q   <= sq_d;
      tick_q <= tick_d;
    end
  end

  assign tick = tick_q;
  assign sq   = sq_q;

endmodule

// File: rtl/multi_clk_div.sv
// Multi-channel clock-enable / square-wave generator in the safe_clk domain.
module multi_clk_div
  import multi_clk_div_pkg::*;
#(
  parameter int unsigned CHANNELS     = 4,
  parameter int unsigned CNT_W        = 20,
  parameter int unsigned DEFAULT_HALF = DEFAULT_HALF_DEF,
  parameter int unsigned SEL_W        = sel_width(CHANNELS)
) (
  input  logic                safe_clk,
  input  logic                safe_reset,
  input  logic [CHANNELS-1:0] en,
  input  logic                sync,
  input  logic                div_wr,
  input  logic [SEL_W-1:0]    div_sel,
  input  logic [CNT_W-1:0]    div_val,
  output logic [CHANNELS-1:0] tick,
  output logic [CHANNELS-1:0] sq_out
);

  logic [CHANNELS-1:0] wr;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    // Full-width compare so out-of-range selects match no channel
    assign wr[i] = div_wr && (div_sel == SEL_W'(i));

    div_channel #(
      .CNT_W       (CNT_W),
      .DEFAULT_HALF(DEFAULT_HALF)
    ) u_ch (
      .clk   (safe_clk),
      .rst   (safe_reset),
      .en    (en[i]),
      .clr   (sync),
      .wr    (wr[i]),
      .wr_val(div_val),
      .tick  (tick[i]),
      .sq    (sq_out[i])
    );
  end

endmodule
